// File: rtl/des_pkg.sv
// Shared DES sequencing constants, FSM encoding and a counter-width helper
// for the L/R half-block sequencer and its round/iteration counter.
package des_pkg;

    localparam int DES_ROUNDS    = 16;
    localparam int DESCRYPT_ITER = 25;
    localparam int HALF_W        = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    // Counter width for a count range of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/des_round_iter_ctr.sv
// Latency / round / iteration counters for the DES round schedule, with the
// capture strobe (end of a round) and the last strobe (end of the candidate).
module des_round_iter_ctr
    import des_pkg::*;
#(
    parameter int ROUNDS     = DES_ROUNDS,
    parameter int ITERATIONS = DESCRYPT_ITER,
    parameter int RND_LAT    = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       run_i,
    output logic       capture_o,
    output logic       last_o,
    output logic [3:0] rnd_idx_o
);

    localparam int LAT_W = cnt_w(RND_LAT + 1);
    localparam int IT_W  = cnt_w(ITERATIONS);

    logic [LAT_W-1:0] lat_q, lat_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [IT_W-1:0]  it_q,  it_d;
    logic             lat_end_s;
    logic             rnd_end_s;
    logic             it_end_s;

    assign lat_end_s = (lat_q == LAT_W'(RND_LAT));
    assign rnd_end_s = (rnd_q == 4'(ROUNDS - 1));
    assign it_end_s  = (it_q  == IT_W'(ITERATIONS - 1));

    assign capture_o = run_i & lat_end_s;
    assign last_o    = run_i & lat_end_s & rnd_end_s & it_end_s;
    assign rnd_idx_o = rnd_q;

    // Next-count logic: lat_cnt wraps each round, rnd_cnt each pass, it_cnt each candidate.
    always_comb begin
        lat_d = lat_q;
        rnd_d = rnd_q;
        it_d  = it_q;
        if (clear_i) begin
            lat_d = '0;
            rnd_d = '0;
            it_d  = '0;
        end else if (run_i) begin
            if (lat_end_s) begin
                lat_d = '0;
                if (rnd_end_s) begin
                    rnd_d = '0;
                    if (it_end_s) begin
                        it_d = '0;
                    end else begin
                        it_d = it_q + IT_W'(1);
                    end
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end else begin
                lat_d = lat_q + LAT_W'(1);
            end
        end else begin
            lat_d = lat_q;
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lat_q <= '0;
            rnd_q <= '0;
            it_q  <= '0;
        end else begin
            lat_q <= lat_d;
            rnd_q <= rnd_d;
            it_q  <= it_d;
        end
    end

endmodule

// File: rtl/des_lr_sequencer.sv
// DES L/R half-block sequencer: runs ROUNDS x ITERATIONS Feistel rounds around an
// external f-function/XOR pipeline and emits the final preoutput with a DONE pulse.
module des_lr_sequencer
    import des_pkg::*;
#(
    parameter int ROUNDS     = DES_ROUNDS,
    parameter int ITERATIONS = DESCRYPT_ITER,
    parameter int RND_LAT    = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [2*HALF_W-1:0]   BLOCK_IN,
    output logic [HALF_W-1:0]     R_OUT,
    output logic [HALF_W-1:0]     L_OUT,
    output logic [3:0]            ROUND_IDX,
    input  logic [HALF_W-1:0]     XOR_IN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [2*HALF_W-1:0]   BLOCK_OUT
);

    seq_state_e          state_q, state_d;
    logic [HALF_W-1:0]   l_q, l_d;
    logic [HALF_W-1:0]   r_q, r_d;
    logic [2*HALF_W-1:0] bo_q, bo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept_s;
    logic                run_s;
    logic                capture_s;
    logic                last_s;
    logic [3:0]          rnd_idx_s;

    assign accept_s = (state_q == IDLE) & START;
    assign run_s    = (state_q == RUN);

    des_round_iter_ctr #(
        .ROUNDS     (ROUNDS),
        .ITERATIONS (ITERATIONS),
        .RND_LAT    (RND_LAT)
    ) u_ctr (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .clear_i   (accept_s),
        .run_i     (run_s),
        .capture_o (capture_s),
        .last_o    (last_s),
        .rnd_idx_o (rnd_idx_s)
    );

    // FSM next state and L/R datapath; the final round of a pass is not swapped.
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        bo_d    = bo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    l_d     = BLOCK_IN[2*HALF_W-1:HALF_W];
                    r_d     = BLOCK_IN[HALF_W-1:0];
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (capture_s) begin
                    if (rnd_idx_s == 4'(ROUNDS - 1)) begin
                        l_d = XOR_IN;
                        if (last_s) begin
                            bo_d    = {XOR_IN, r_q};
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        l_d = r_q;
                        r_d = XOR_IN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
    end

    // State, half-block and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            l_q     <= '0;
            r_q     <= '0;
            bo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            bo_q    <= bo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign L_OUT     = l_q;
    assign R_OUT     = r_q;
    assign ROUND_IDX = rnd_idx_s;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign BLOCK_OUT = bo_q;

endmodule

// File: tb/tb_des_lr_sequencer.sv
// Bench for des_lr_sequencer: four configurations, each driven through a modelled
// f/XOR pipeline and checked against a plain Feistel reference model.
module tb_des_lr_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    bit          fmode;
    logic [31:0] subkey    [16];
    logic        start     [4];
    logic [63:0] block_in  [4];
    logic [31:0] r_out     [4];
    logic [31:0] l_out     [4];
    logic [31:0] xor_in    [4];
    logic [3:0]  round_idx [4];
    logic        busy      [4];
    logic        done      [4];
    logic [63:0] block_out [4];

    int n_pass  = 0;
    int n_total = 0;

    // Keyed stand-in for the E/key-mix/S/P path: any fixed nonlinear map of (R, round) will do.
    function automatic logic [31:0] fkey(input logic [31:0] r, input logic [3:0] k);
        return ({r[28:0], r[31:29]} + subkey[k]) ^ {r[15:0], r[31:16]} ^ 32'h9E37_79B9;
    endfunction

    // Textbook Feistel schedule: 15 swapped rounds, one unswapped, repeated per pass.
    function automatic logic [63:0] model(input logic [63:0] b, input int iters, input bit keyed);
        logic [31:0] lv, rv, t;
        lv = b[63:32];
        rv = b[31:0];
        for (int i = 0; i < iters; i++) begin
            for (int r = 0; r < 16; r++) begin
                t = lv ^ (keyed ? fkey(rv, 4'(r)) : 32'd0);
                if (r == 15) begin
                    lv = t;
                end else begin
                    lv = rv;
                    rv = t;
                end
            end
        end
        return {lv, rv};
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LAT = (g == 3) ? 1 : 2;
        localparam int IT  = (g == 0) ? 25 : ((g == 2) ? 2 : 1);
        logic [31:0] pipe [LAT];

        always @(posedge clk) begin
            pipe[0] <= l_out[g] ^ (fmode ? fkey(r_out[g], round_idx[g]) : 32'd0);
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign xor_in[g] = pipe[LAT-1];

        des_lr_sequencer #(
            .ROUNDS     (16),
            .ITERATIONS (IT),
            .RND_LAT    (LAT)
        ) u_dut (
            .CLK       (clk),
            .RST_N     (rst_n),
            .START     (start[g]),
            .BLOCK_IN  (block_in[g]),
            .R_OUT     (r_out[g]),
            .L_OUT     (l_out[g]),
            .ROUND_IDX (round_idx[g]),
            .XOR_IN    (xor_in[g]),
            .BUSY      (busy[g]),
            .DONE      (done[g]),
            .BLOCK_OUT (block_out[g])
        );
    end

    task automatic new_keys();
        for (int k = 0; k < 16; k++) subkey[k] = $urandom;
    endtask

    // Starts a candidate on instance g and observes it until DONE (bounded).
    task automatic run_cand(input int g, input logic [63:0] blk, input int lat,
                            output int dc, output int busy_err, output int idx_err,
                            output logic [63:0] bo);
        dc = -1; busy_err = 0; idx_err = 0; bo = '0;
        block_in[g] = blk;
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        block_in[g] = {$urandom, $urandom};
        for (int c = 1; c <= 4000; c++) begin
            if (done[g] === 1'b1) begin
                dc = c;
                bo = block_out[g];
                if (busy[g] !== 1'b0) busy_err++;
                break;
            end
            if (busy[g] !== 1'b1) busy_err++;
            if (round_idx[g] !== 4'(((c - 1) / (lat + 1)) % 16)) idx_err++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fmode = 1'b0;
        new_keys();
        for (int g = 0; g < 4; g++) begin
            start[g] = 1'b0;
            block_in[g] = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            n_total++;
            if ({r_out[g], l_out[g], round_idx[g], busy[g], done[g], block_out[g]} !== 134'd0)
                $display("FAIL reset_outputs inst%0d: got %h required 0", g,
                         {r_out[g], l_out[g], round_idx[g], busy[g], done[g], block_out[g]});
            else n_pass++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Shared body for the short configurations: fixed zero-f vector, then keyed random blocks.
    task automatic test_short_cfg(input int g, input int lat, input int iters,
                                  input logic [63:0] zero_f_exp);
        int dc, be, ie, n_exp;
        logic [63:0] bo, blk, exp_bo;
        n_exp = 16 * iters * (lat + 1) + 1;
        fmode = 1'b0;
        run_cand(g, 64'hAAAAAAAA_55555555, lat, dc, be, ie, bo);
        n_total++;
        if (bo !== zero_f_exp) $display("FAIL zero_f_block inst%0d: got %h required %h", g, bo, zero_f_exp);
        else n_pass++;
        n_total++;
        if (dc !== n_exp) $display("FAIL zero_f_done_cycle inst%0d: got %0d required %0d", g, dc, n_exp);
        else n_pass++;
        n_total++;
        if (be !== 0 || ie !== 0) $display("FAIL busy_roundidx inst%0d: got busy_err=%0d idx_err=%0d required 0", g, be, ie);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done[g] !== 1'b0 || block_out[g] !== zero_f_exp)
            $display("FAIL done_pulse_hold inst%0d: got done=%b out=%h required 0/%h", g, done[g], block_out[g], zero_f_exp);
        else n_pass++;
        fmode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            new_keys();
            blk = {$urandom, $urandom};
            exp_bo = model(blk, iters, 1'b1);
            run_cand(g, blk, lat, dc, be, ie, bo);
            n_total++;
            if (bo !== exp_bo || dc !== n_exp)
                $display("FAIL keyed_block inst%0d: got %h @%0d required %h @%0d", g, bo, dc, exp_bo, n_exp);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_identity_f();
        test_short_cfg(1, 2, 1, 64'h55555555_AAAAAAAA);
    endtask

    task automatic test_iteration_feedback();
        test_short_cfg(2, 2, 2, 64'hAAAAAAAA_55555555);
    endtask

    task automatic test_min_latency();
        test_short_cfg(3, 1, 1, 64'h55555555_AAAAAAAA);
    endtask

    task automatic test_default_timing();
        int busy_err, done_err, dc, be, ie;
        logic [63:0] blk0, blk1, bo;
        fmode = 1'b1;
        new_keys();
        blk0 = {$urandom, $urandom};
        busy_err = 0; done_err = 0;
        block_in[0] = blk0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int c = 1; c <= 1201; c++) begin
            if (busy[0] !== (c <= 1200)) busy_err++;
            if (done[0] !== (c == 1201)) done_err++;
            if (c == 500 || c == 1200) begin
                start[0] = 1'b1;
                block_in[0] = {$urandom, $urandom};
            end else if (c < 1201) begin
                start[0] = 1'b0;
            end
            if (c < 1201) @(negedge clk);
        end
        n_total++;
        if (busy_err !== 0) $display("FAIL default_busy_window: got %0d bad cycles required 0", busy_err);
        else n_pass++;
        n_total++;
        if (done_err !== 0) $display("FAIL default_done_cycle: got %0d bad cycles required 0", done_err);
        else n_pass++;
        n_total++;
        if (block_out[0] !== model(blk0, 25, 1'b1))
            $display("FAIL default_block: got %h required %h", block_out[0], model(blk0, 25, 1'b1));
        else n_pass++;
        blk1 = {$urandom, $urandom};
        run_cand(0, blk1, 2, dc, be, ie, bo);
        n_total++;
        if (dc !== 1201 || bo !== model(blk1, 25, 1'b1))
            $display("FAIL back_to_back: got %h @%0d required %h @1201", bo, dc, model(blk1, 25, 1'b1));
        else n_pass++;
        n_total++;
        if (be !== 0 || ie !== 0) $display("FAIL back_to_back_busy_idx: got busy_err=%0d idx_err=%0d required 0", be, ie);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int dc, be, ie;
        logic [63:0] blk, bo;
        fmode = 1'b1;
        new_keys();
        block_in[0] = {$urandom, $urandom};
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int c = 1; c < 300; c++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_total++;
        if ({r_out[0], l_out[0], round_idx[0], busy[0], done[0], block_out[0]} !== 134'd0)
            $display("FAIL midrun_reset_outputs: got %h required 0",
                     {r_out[0], l_out[0], round_idx[0], busy[0], done[0], block_out[0]});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy[0] !== 1'b0) $display("FAIL midrun_reset_idle: got busy=%b required 0", busy[0]);
        else n_pass++;
        blk = {$urandom, $urandom};
        run_cand(0, blk, 2, dc, be, ie, bo);
        n_total++;
        if (dc !== 1201 || bo !== model(blk, 25, 1'b1))
            $display("FAIL post_reset_run: got %h @%0d required %h @1201", bo, dc, model(blk, 25, 1'b1));
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_identity_f();
        test_iteration_feedback();
        test_min_latency();
        test_default_timing();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/des_lr_sequencer.md
# des_lr_sequencer

Holds the DES L/R half-block registers and runs the 16-round × ITERATIONS schedule for one descrypt candidate. It drives R into the f-function path and L into the `X` input of the downstream registered 32-bit XOR stage. It takes that stage's `Dout` back as the new half-block and emits the final preoutput block with a one-cycle DONE pulse.

## Interface
- `ROUNDS`, 16: rounds per DES pass (fixed by the algorithm; parameter for bench shortening only).
- `ITERATIONS`, 25: DES passes per candidate (descrypt). Must be ≥1.
- `RND_LAT`, 2: register stages between `R_OUT`/`L_OUT` and `XOR_IN` (f-function stages + 1 for the XOR stage). Must be ≥1.

Ports:
- `CLK` in 1: the single clock.
- `RST_N` in 1: synchronous, active-low reset.
- `START` in 1: begin a candidate. Sampled only in IDLE.
- `BLOCK_IN` in 64: initial {L0,R0} (post-IP), captured with `START`.
- `R_OUT` out 32: current R, to the E/key-mix/S/P path.
- `L_OUT` out 32: current L, to the XOR stage `X` input.
- `ROUND_IDX` out 4: subkey select for the key schedule, 0..ROUNDS-1.
- `XOR_IN` in 32: XOR stage `Dout` (L ^ f(R,K)).
- `BUSY` out 1: high in RUN.
- `DONE` out 1: one-cycle pulse when `BLOCK_OUT` becomes valid.
- `BLOCK_OUT` out 64: final {L,R} preoutput. Held until the next `START` is accepted.

## Operation
- FSM states: IDLE, RUN.
- Counters:
  - `lat_cnt` runs 0..RND_LAT.
  - `rnd_cnt` runs 0..ROUNDS-1 and drives `ROUND_IDX`.
  - `it_cnt` runs 0..ITERATIONS-1, width $clog2(ITERATIONS) with a minimum of 1.
- IDLE with `START`=1: at that edge L<=BLOCK_IN[63:32], R<=BLOCK_IN[31:0], all counters<=0, go to RUN.
- RUN: L, R and `ROUND_IDX` are held constant for the whole round, which is RND_LAT+1 cycles. `XOR_IN` is sampled at the end of the cycle where `lat_cnt`==RND_LAT.
- Round capture for `rnd_cnt` < ROUNDS-1: L<=R, R<=XOR_IN.
- Round capture for `rnd_cnt`==ROUNDS-1 (the unswapped final round): L<=XOR_IN, R unchanged. The result {L,R} is the preoutput, and it is the next pass's {L0,R0` because IP∘FP is the identity.
- Counter wrap at capture:
  - `rnd_cnt` wraps 15→0 and increments `it_cnt`.
  - On the last capture (`rnd_cnt`==ROUNDS-1 and `it_cnt`==ITERATIONS-1): `BLOCK_OUT`<={new L, R}, `DONE`<=1, go to IDLE.
- `START` in RUN is ignored; no queueing.
- `START` in the DONE cycle (which is already IDLE) is accepted.
- `XOR_IN` is ignored outside capture cycles.
- Reset (any state, including mid-candidate):
  - State IDLE and all counters 0.
  - L, R, `BLOCK_OUT` = 0.
  - `BUSY`=0, `DONE`=0, `ROUND_IDX`=0.
  - The in-flight candidate is discarded. The external pipeline contents are don't-care, because the first post-reset round waits the full RND_LAT+1.
- All outputs are registered. `R_OUT`/`L_OUT` are the L/R registers directly.

## Timing
- Cycle 0: `START`=1 in IDLE.
- Cycles 1..N, with N = ROUNDS·ITERATIONS·(RND_LAT+1):
  - `BUSY`=1.
  - Round k occupies cycles 1+k(RND_LAT+1) .. (k+1)(RND_LAT+1).
- Cycle N+1: `DONE`=1, `BUSY`=0, `BLOCK_OUT` valid.
- Defaults: N = 16·25·3 = 1200, so `DONE` is in cycle 1201.
- Back-to-back: `START` in cycle N+1 gives the next `DONE` in cycle 2N+2.
- `L_OUT` is stable for all RND_LAT+1 cycles of a round. This satisfies the XOR stage sampling `X` in the cycle before `XOR_IN` is valid.

## Structure
- Shared package `des_pkg` holds:
  - DES_ROUNDS=16.
  - DESCRYPT_ITER=25.
  - Half-block width 32.
  - State encoding IDLE/RUN.
- One sub-module, `des_round_iter_ctr`, contains `lat_cnt`/`rnd_cnt`/`it_cnt` with `capture` and `last` strobes. The FSM and datapath stay in the top.

## Test plan
- **Identity f.** ITERATIONS=1, RND_LAT=2, bench f-stub =0 (`XOR_IN` = delayed `L_OUT`), `BLOCK_IN`=0xAAAAAAAA_55555555 → `BLOCK_OUT`=0x55555555_AAAAAAAA, `DONE` in cycle 49.
- **Iteration feedback.** Same setup, ITERATIONS=2 → `BLOCK_OUT`=0xAAAAAAAA_55555555, `DONE` in cycle 97.
- **Real DES.**
  - Setup: real f-path and key schedule, key 133457799BBCDFF1, `BLOCK_IN`=IP(0123456789ABCDEF), ITERATIONS=1.
  - Expected: FP(`BLOCK_OUT`)=85E813540F0AB405.
  - `ROUND_IDX` steps 0..15, each value held exactly 3 cycles.
- **Default timing.** Defaults, `START` cycle 0 → `BUSY` cycles 1..1200, `DONE` only in cycle 1201. `START` pulses at cycles 500 and 1200 are ignored; `START` at cycle 1201 is accepted.
- **Reset mid-run.** `RST_N`=0 for 1 cycle at cycle 300 → next cycle all outputs 0, IDLE. A fresh `START` then gives a correct result and `DONE` exactly N+1 cycles later.
- **Minimum latency.** RND_LAT=1, ITERATIONS=1, f-stub=0 → rounds of 2 cycles, `DONE` in cycle 33, `BLOCK_OUT` matches the identity-f case.
